// File: rtl/buyruk_onbellegi_param.sv
// buyruk_onbellegi_param
// Direct-mapped instruction cache between a halfword-addressed fetch port and a
// valid/ready memory read port. Each of the 2^INDEX_W lines holds one 32-bit
// word. A fetch with address bit 1 set spans two consecutive words (A and A+1)
// and is served only when both words are present.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset (state, valid bits, flush flag)
//   l1b_adres_i  fetch address, byte-address bits [ADDR_W-1:1]
//   l1b_deger_o  instruction, meaningful while l1b_bekle_o is low
//   l1b_bekle_o  stall request to the fetch stage
//   flush_i      invalidate every line (pulse or level)
//   iomem_valid  memory read request
//   iomem_ready  memory read completion, iomem_rdata valid in this cycle
//   iomem_addr   word address of the read, byte-address bits [ADDR_W-1:2]
//   iomem_rdata  memory read data
//
// TAG_W = ADDR_W-2-INDEX_W must be at least 1.
module buyruk_onbellegi_param #(
  parameter int ADDR_W  = 19,
  parameter int INDEX_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-2:0] l1b_adres_i,
  output logic [31:0]       l1b_deger_o,
  output logic              l1b_bekle_o,
  input  logic              flush_i,
  output logic              iomem_valid,
  input  logic              iomem_ready,
  output logic [ADDR_W-3:0] iomem_addr,
  input  logic [31:0]       iomem_rdata
);

  localparam int WADDR_W = ADDR_W - 2;
  localparam int TAG_W   = WADDR_W - INDEX_W;
  localparam int LINES   = 1 << INDEX_W;

  typedef enum logic [1:0] {
    LOOKUP = 2'd0,
    FILL_A = 2'd1,
    FILL_B = 2'd2,
    FLUSH  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic               flush_pend_q;
  logic [WADDR_W-1:0] fill_addr_q, fill_addr_d;

  logic [WADDR_W-1:0] word_a, word_b;
  logic [INDEX_W-1:0] idx_a, idx_b, fill_idx;
  logic [TAG_W-1:0]   tag_a, tag_b, fill_tag;
  logic [31:0]        data_a, data_b;
  logic               unaligned, hit_a, hit_b, flush_req, in_fill, fill_we;

  // Word B is computed at the full word-address width so that an index wrap
  // carries into the tag, and the top word wraps to word 0.
  assign word_a    = l1b_adres_i[ADDR_W-2:1];
  assign unaligned = l1b_adres_i[0];
  assign word_b    = word_a + WADDR_W'(1);

  assign idx_a = word_a[INDEX_W-1:0];
  assign tag_a = word_a[WADDR_W-1:INDEX_W];
  assign idx_b = word_b[INDEX_W-1:0];
  assign tag_b = word_b[WADDR_W-1:INDEX_W];

  assign data_a = data_q[idx_a];
  assign data_b = data_q[idx_b];
  assign hit_a  = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
  assign hit_b  = valid_q[idx_b] && (tag_q[idx_b] == tag_b);

  // A flush request seen in LOOKUP takes effect even before the flag is set.
  assign flush_req = flush_pend_q | flush_i;

  assign in_fill  = (state_q == FILL_A) || (state_q == FILL_B);
  assign fill_we  = in_fill && iomem_ready;
  assign fill_idx = fill_addr_q[INDEX_W-1:0];
  assign fill_tag = fill_addr_q[WADDR_W-1:INDEX_W];

  assign l1b_deger_o = unaligned ? {data_b[15:0], data_a[31:16]} : data_a;

  // The request is driven purely from registered state so it stays stable
  // until the memory answers.
  assign iomem_valid = in_fill;
  assign iomem_addr  = fill_addr_q;

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    l1b_bekle_o = 1'b1;
    case (state_q)
      LOOKUP: begin
        if (flush_req) begin
          state_d = FLUSH;
        end else if (!hit_a) begin
          fill_addr_d = word_a;
          state_d     = FILL_A;
        end else if (unaligned && !hit_b) begin
          fill_addr_d = word_b;
          state_d     = FILL_B;
        end else begin
          l1b_bekle_o = 1'b0;
        end
      end
      FILL_A, FILL_B: begin
        if (iomem_ready) state_d = LOOKUP;
      end
      FLUSH: begin
        state_d = LOOKUP;
      end
      default: begin
        state_d = LOOKUP;
      end
    endcase
    if (rst_i) l1b_bekle_o = 1'b1;
  end

  // Control: state, valid bits and pending flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= LOOKUP;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_we) valid_q[fill_idx] <= 1'b1;
      if (state_q == FLUSH) begin
        valid_q      <= '0;
        flush_pend_q <= 1'b0;
      end
      // A new request arriving during FLUSH is kept for another pass.
      if (flush_i) flush_pend_q <= 1'b1;
    end
  end

  // Storage and fill address: no reset; a fill abandoned by reset writes nothing.
  always_ff @(posedge clk_i) begin
    fill_addr_q <= fill_addr_d;
    if (fill_we && !rst_i) begin
      data_q[fill_idx] <= iomem_rdata;
      tag_q[fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_buyruk_onbellegi_param.sv
// tb_buyruk_onbellegi_param
// Self-checking bench for buyruk_onbellegi_param. A memory responder serves
// reads from a fixed word-to-data function, a behavioural model tracks which
// words the cache holds, and a per-cycle compare process checks stall, request
// and instruction outputs. Directed scenarios pin literal values; a random
// phase then mixes addresses, flushes, resets and memory latencies.
`timescale 1ns/1ps
module tb_buyruk_onbellegi_param;

  localparam int ADDR_W  = 19;
  localparam int INDEX_W = 9;
  localparam int WA_W    = ADDR_W - 2;
  localparam int LINES   = 1 << INDEX_W;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              iomem_ready = 1'b0;
  logic [ADDR_W-2:0] l1b_adres_i = '0;
  logic [31:0]       iomem_rdata = '0;
  logic [31:0]       l1b_deger_o;
  logic              l1b_bekle_o;
  logic              iomem_valid;
  logic [WA_W-1:0]   iomem_addr;

  always #5 clk = ~clk;

  buyruk_onbellegi_param #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .l1b_adres_i (l1b_adres_i),
    .l1b_deger_o (l1b_deger_o),
    .l1b_bekle_o (l1b_bekle_o),
    .flush_i     (flush_i),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_addr  (iomem_addr),
    .iomem_rdata (iomem_rdata)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endfunction

  // Backing memory: fixed function of the word address, with overrides.
  logic [31:0] mem_ovr [int];

  function automatic logic [31:0] mem(int w);
    if (mem_ovr.exists(w)) return mem_ovr[w];
    return (32'(w) * 32'h9E3779B1) ^ 32'hC3A50F0F;
  endfunction

  // Behavioural model: which words are resident, plus the controller phase.
  int m_mode = 0;            // 0 lookup, 1 fill outstanding, 2 flushing
  int m_fa = 0;
  bit m_valid [LINES];
  int m_tag [LINES];
  bit m_pend = 1'b0;

  function automatic bit m_hit(int w);
    return m_valid[w % LINES] && (m_tag[w % LINES] == w / LINES);
  endfunction

  function automatic int word_a_of(logic [ADDR_W-2:0] adr);
    return int'(adr) >> 1;
  endfunction

  function automatic int word_b_of(logic [ADDR_W-2:0] adr);
    return ((int'(adr) >> 1) + 1) % (1 << WA_W);
  endfunction

  always @(posedge clk) begin
    int a, b;
    bit un;
    a  = word_a_of(l1b_adres_i);
    b  = word_b_of(l1b_adres_i);
    un = l1b_adres_i[0];
    if (rst_i) begin
      m_mode = 0;
      m_pend = 1'b0;
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    end else begin
      case (m_mode)
        0: begin
          m_pend = m_pend || flush_i;
          if (m_pend) m_mode = 2;
          else if (!m_hit(a)) begin m_fa = a; m_mode = 1; end
          else if (un && !m_hit(b)) begin m_fa = b; m_mode = 1; end
        end
        1: begin
          if (flush_i) m_pend = 1'b1;
          if (iomem_ready) begin
            m_valid[m_fa % LINES] = 1'b1;
            m_tag[m_fa % LINES]   = m_fa / LINES;
            m_mode = 0;
          end
        end
        default: begin
          for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
          m_pend = flush_i;
          m_mode = 0;
        end
      endcase
    end
  end

  // Per-cycle compare against the model.
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    int a, b;
    bit un, eb;
    logic [31:0] da, db, ed;
    if (chk_en) begin
      a  = word_a_of(l1b_adres_i);
      b  = word_b_of(l1b_adres_i);
      un = l1b_adres_i[0];
      check("iomem_valid", 32'(iomem_valid), 32'(m_mode == 1));
      if (m_mode == 1) check("iomem_addr", 32'(iomem_addr), 32'(m_fa));
      eb = rst_i || (m_mode != 0) || m_pend || flush_i || !m_hit(a) || (un && !m_hit(b));
      check("bekle", 32'(l1b_bekle_o), 32'(eb));
      if (!eb && !l1b_bekle_o) begin
        da = mem(a);
        db = mem(b);
        ed = un ? {db[15:0], da[31:16]} : da;
        check("deger", l1b_deger_o, ed);
      end
    end
  end

  // Memory responder.
  int wait_n = 0;
  int wcnt = 0;
  bit rnd_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    if (iomem_valid) begin
      if (wcnt >= wait_n) begin
        iomem_ready = 1'b1;
        iomem_rdata = mem(int'(iomem_addr));
        wcnt = 0;
        if (rnd_mode) wait_n = $urandom_range(0, 3);
      end else begin
        iomem_ready = 1'b0;
        iomem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      iomem_rdata = $urandom;
      iomem_ready = rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Request log: address and cycle of every rising iomem_valid.
  int cyc_n = 0;
  int req_addr[$];
  int req_cyc[$];
  bit prev_v = 1'b0;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (iomem_valid && !prev_v) begin
      req_addr.push_back(int'(iomem_addr));
      req_cyc.push_back(cyc_n);
    end
    prev_v = iomem_valid;
  end

  function automatic int req_a(int i);
    return (i < req_addr.size()) ? req_addr[i] : -1;
  endfunction

  function automatic int req_c(int i);
    return (i < req_cyc.size()) ? req_cyc[i] : -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-2:0] fa(int byte_addr);
    return (ADDR_W-1)'(byte_addr >> 1);
  endfunction

  // Hold reset for one edge with the given fetch address, then release.
  task automatic reset_to(int byte_addr, int wn);
    rst_i = 1'b1;
    l1b_adres_i = fa(byte_addr);
    wait_n = wn;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic run_until_hit(input int maxc, output int kf, output logic [31:0] val);
    kf = -1;
    val = '0;
    for (int k = 0; k < maxc && kf < 0; k++) begin
      @(negedge clk);
      if (!l1b_bekle_o) begin
        kf = k;
        val = l1b_deger_o;
      end
      tick();
    end
  endtask

  int words[11] = '{32'h40, 32'h41, 32'h1FF, 32'h200, 32'h0, 32'h1,
                    32'h1FFFF, 32'h240, 32'h3FF, 32'h400, 32'h80};

  initial begin
    int kf, r0, c0;
    logic [31:0] val;

    tick();
    chk_en = 1'b1;

    // Aligned cold miss with three memory wait cycles.
    mem_ovr[32'h40] = 32'hDEADBEEF;
    reset_to(32'h100, 3);
    r0 = req_addr.size();
    run_until_hit(20, kf, val);
    check("s1_latency", 32'(kf), 32'd5);
    check("s1_data", val, 32'hDEADBEEF);
    check("s1_nreq", 32'(req_addr.size() - r0), 32'd1);
    check("s1_addr", 32'(req_a(r0)), 32'h40);
    @(negedge clk);
    check("s1_refetch_bekle", 32'(l1b_bekle_o), 32'd0);
    check("s1_refetch_data", l1b_deger_o, 32'hDEADBEEF);
    tick();

    // Unaligned fetch with both words cold.
    rst_i = 1'b1;
    mem_ovr[32'h40] = 32'h11112222;
    mem_ovr[32'h41] = 32'h33334444;
    reset_to(32'h102, 1);
    r0 = req_addr.size();
    run_until_hit(30, kf, val);
    check("s2_nreq", 32'(req_addr.size() - r0), 32'd2);
    check("s2_req0", 32'(req_a(r0)), 32'h40);
    check("s2_req1", 32'(req_a(r0 + 1)), 32'h41);
    check("s2_data", val, 32'h44441111);

    // Unaligned fetch wrapping past the last index.
    reset_to(32'h7FE, 0);
    r0 = req_addr.size();
    run_until_hit(30, kf, val);
    check("s3_req0", 32'(req_a(r0)), 32'h1FF);
    check("s3_req1", 32'(req_a(r0 + 1)), 32'h200);
    l1b_adres_i = fa(32'h000);
    @(negedge clk);
    check("s3_alias_miss", 32'(l1b_bekle_o), 32'd1);
    tick();
    run_until_hit(30, kf, val);
    check("s3_alias_req", 32'(req_a(r0 + 2)), 32'h0);

    // Address changes while the fill waits.
    reset_to(32'h100, 6);
    r0 = req_addr.size();
    tick();
    tick();
    l1b_adres_i = fa(32'h200);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("s4_hold_valid", 32'(iomem_valid), 32'd1);
      check("s4_hold_addr", 32'(iomem_addr), 32'h40);
      tick();
    end
    run_until_hit(30, kf, val);
    check("s4_nreq", 32'(req_addr.size() - r0), 32'd2);
    check("s4_req1", 32'(req_a(r0 + 1)), 32'h80);

    // Flush pulse during a pending fill.
    reset_to(32'h100, 4);
    r0 = req_addr.size();
    c0 = cyc_n;
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    run_until_hit(40, kf, val);
    check("s5_nreq", 32'(req_addr.size() - r0), 32'd2);
    check("s5_req0_cyc", 32'(req_c(r0) - c0), 32'd1);
    check("s5_req1_addr", 32'(req_a(r0 + 1)), 32'h40);
    check("s5_req1_cyc", 32'(req_c(r0 + 1) - c0), 32'd9);

    // Reset while a request is outstanding.
    reset_to(32'h100, 10);
    r0 = req_addr.size();
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    @(negedge clk);
    check("s6_valid_dropped", 32'(iomem_valid), 32'd0);
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("s6_miss_after_reset", 32'(l1b_bekle_o), 32'd1);
    tick();
    run_until_hit(30, kf, val);
    check("s6_nreq", 32'(req_addr.size() - r0), 32'd2);
    check("s6_req1", 32'(req_a(r0 + 1)), 32'h40);

    // Random mix of addresses, flushes, resets and latencies.
    rnd_mode = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0)
        l1b_adres_i = (ADDR_W-1)'((words[$urandom_range(0, 10)] << 1) | int'($urandom_range(0, 1)));
      flush_i = ($urandom_range(0, 49) == 0);
      rst_i = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst_i = 1'b0;
    flush_i = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
